fu_complete_buffer: RTL
=======================

Name: fu_complete_buffer

Overview:
- Per-FU completion queue on the transmit side of the CDB arbiter.
- Accepts completed destination tags from one functional unit and holds them in order.
- Presents the oldest tag to the CDB as a completion request, and pops it when the CDB grants that FU's slot.
- Absorbs cycles where the CDB arbiter withholds the grant, so the FU pipeline keeps moving until the buffer fills.

Parameters:
DEPTH, 4, number of buffered completions; power of two, at least 2
PREG_NUMBER, 32, physical register count; tag width TW = $clog2(PREG_NUMBER)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
fu_done_i  input  1  FU has a completed instruction this cycle
fu_tag_i  input  TW  destination physical register tag of the completion
buf_ready_o  output  1  buffer can accept a push this cycle
flush_i  input  1  squash all buffered completions (mispredict recovery)
FU_complete_o  output  1  completion request to CDB (head valid)
completed_tag_o  output  TW  tag of head entry; 0 when FU_complete_o=0
FU_complete_en_i  input  1  CDB grant for this FU, same cycle as request
count_o  output  $clog2(DEPTH)+1  occupied entries
overflow_o  output  1  sticky: push attempted while full

Behaviour:
- One clock, clk; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - Pointers and count are 0.
  - FU_complete_o=0, completed_tag_o=0, buf_ready_o=1, count_o=0, overflow_o=0.
- Storage: circular array of DEPTH tags with head and tail pointers of $clog2(DEPTH) bits, wrapping mod DEPTH. Count is a separate counter from 0 to DEPTH.
- buf_ready_o = (count < DEPTH). It is registered-state only and does not account for a same-cycle pop, so there is no combinational path from the CDB grant.
- Push: fu_done_i && buf_ready_o && !flush_i. Writes fu_tag_i at tail; tail+1.
- Push while full (fu_done_i && !buf_ready_o && !flush_i): tag dropped, state unchanged, overflow_o set to 1. overflow_o stays 1 until reset.
- Request: FU_complete_o = (count != 0). completed_tag_o = the head entry, forced to 0 when empty.
- Pop: FU_complete_o && FU_complete_en_i && !flush_i. head+1.
- A grant while FU_complete_o=0 is ignored.
- Latency: without bypass, a pushed tag is visible on FU_complete_o on the cycle after the push edge.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any occupancy except push-when-full, which is dropped per the rule above even if a pop occurs.
- Ordering is strict FIFO; tags leave in push order.
- Request is held stable while ungranted: FU_complete_o stays 1 and completed_tag_o holds its value until a pop or flush.
- flush_i:
  - Next state is empty: pointers 0, count 0.
  - Push and pop in the flush cycle are discarded.
  - Outputs in the flush cycle still reflect pre-flush state.
  - overflow_o is not cleared by flush.
- Priority: reset > flush > push/pop.
- Reset mid-operation drops every entry; the next cycle matches the reset values.
- Tag value 0 is a legal tag. Validity is carried only by FU_complete_o.

Optional Feature:
CPL_BYPASS_EN
- Defined: when count==0 and fu_done_i && !flush_i, FU_complete_o=1 and completed_tag_o=fu_tag_i combinationally in the same cycle.
  - If FU_complete_en_i is also 1, the completion is consumed and not written; count stays 0.
  - If the grant is absent, the tag is written as a normal push.
  - With a non-empty buffer, behaviour is identical to the non-bypass build.
- Undefined: no bypass. Completion latency is at least 1 cycle and outputs depend only on registered state plus the zero-forcing rule.

Test Plan:
- Reset, then idle -> FU_complete_o=0, completed_tag_o=0, buf_ready_o=1, count_o=0, overflow_o=0.
- Push tags 8,12,9 on consecutive cycles with FU_complete_en_i=0 -> count_o 1,2,3, completed_tag_o=8 held. Then grant 3 cycles -> tags 8,12,9 appear in order; afterwards FU_complete_o=0 and tag_o=0.
- Fill with 1,2,3,4 (DEPTH=4) -> buf_ready_o=0. Push 5 -> dropped, overflow_o=1, count_o=4. Grant all -> 1,2,3,4 out, 5 never appears. overflow_o stays 1.
- Wrap-around, at count=2 with head at index 3:
  - Simultaneous push 16 and grant each cycle for 6 cycles -> count_o constant 2, FIFO order preserved across the index 3->0 wrap.
- Buffer holds 4,11 and push 7 coincides with flush_i=1 -> next cycle count_o=0, FU_complete_o=0. Tag 7 never appears; overflow_o unchanged.
- CPL_BYPASS_EN, empty buffer:
  - Push 16 with grant in the same cycle -> FU_complete_o=1, tag_o=16 in that cycle; next cycle count_o=0.
  - Same push without grant -> next cycle FU_complete_o=1, tag_o=16, count_o=1.

Source files
------------

// File: rtl/fu_complete_buffer.sv
// Per-FU completion FIFO feeding the CDB arbiter request/grant slot.
// Optional same-cycle bypass when empty: define CPL_BYPASS_EN.
module fu_complete_buffer #(
  parameter int DEPTH       = 4,
  parameter int PREG_NUMBER = 32,
  localparam int TW = $clog2(PREG_NUMBER),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fu_done_i,
  input  logic [TW-1:0] fu_tag_i,
  output logic          buf_ready_o,
  input  logic          flush_i,
  output logic          FU_complete_o,
  output logic [TW-1:0] completed_tag_o,
  input  logic          FU_complete_en_i,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  logic [TW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_full;
  logic w_nempty;
  logic w_push_req;
  logic w_byp;
  logic w_wr;
  logic w_rd;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nempty   = (r_count != '0);
  assign w_push_req = fu_done_i && !flush_i;

`ifdef CPL_BYPASS_EN
  assign w_byp = !w_nempty && w_push_req;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed completion granted in the same cycle never enters storage.
  assign w_wr = w_push_req && !w_full && !(w_byp && FU_complete_en_i);
  assign w_rd = w_nempty && FU_complete_en_i && !flush_i;

  // Request outputs: head entry, bypass tag, or zero when idle.
  always_comb begin
    FU_complete_o   = w_nempty || w_byp;
    completed_tag_o = '0;
    if (w_nempty)
      completed_tag_o = r_mem[r_head];
    else if (w_byp)
      completed_tag_o = fu_tag_i;
  end

  assign buf_ready_o = !w_full;
  assign count_o     = r_count;
  assign overflow_o  = r_ovf;

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_req && w_full)
        r_ovf <= 1'b1;
      if (flush_i) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_wr)
          r_tail <= r_tail + AW'(1);
        if (w_rd)
          r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
    end
  end

  // Tag storage; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr)
      r_mem[r_tail] <= fu_tag_i;
  end

endmodule
